// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler.
// Standard dividers are derived from the 50 MHz system clock.
package tick_sched_pkg;

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned MAX_CH = 8;
    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [0:0] {
        IDLE,
        APPLY
    } cfg_state_t;

    function automatic int unsigned rate_to_div(input int unsigned hz);
        return CLK_HZ / hz;
    endfunction

    localparam int unsigned DIV_300HZ = rate_to_div(300);
    localparam int unsigned DIV_480HZ = rate_to_div(480);

endpackage

// File: rtl/tick_scheduler_channel.sv
// One divider channel: registered single-cycle tick every i_period cycles.
// Define TICK_PHASE_OUT_EN to build the toggling phase flop.
module tick_channel #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_pause,
    output logic             o_tick,
    output logic             o_phase
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_enabled;
    logic             w_run;
    logic             w_term;

    // A zero period is treated exactly like a disabled channel
    assign w_enabled = i_en && (i_period != '0);
    assign w_run     = w_enabled && !i_pause;
    assign w_term    = (r_cnt == i_period - CNT_W'(1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (w_run) begin
            r_tick <= w_term;
            r_cnt  <= w_term ? '0 : r_cnt + CNT_W'(1);
        end else begin
            r_tick <= 1'b0;
            if (!w_enabled) begin
                r_cnt <= '0;
            end
        end
    end

    assign o_tick = r_tick;

`ifdef TICK_PHASE_OUT_EN
    logic r_phase;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_load) begin
            r_phase <= 1'b0;
        end else if (w_run && w_term) begin
            r_phase <= !r_phase;
        end
    end

    assign o_phase = r_phase;
`else
    assign o_phase = 1'b0;
`endif

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler: NUM_CH programmable tick-enable dividers behind a two-cycle config port.
// Define TICK_PHASE_OUT_EN to drive square-wave phase outputs; otherwise phase is 0.
module tick_scheduler #(
    parameter int unsigned                       NUM_CH   = 4,
    parameter int unsigned                       CNT_W    = tick_sched_pkg::CNT_W,
    parameter int unsigned                       RST_DIV0 = tick_sched_pkg::DIV_300HZ,
    parameter int unsigned                       RST_DIV1 = tick_sched_pkg::DIV_480HZ,
    parameter logic [tick_sched_pkg::MAX_CH-1:0] RST_EN   = 8'h03
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              pause,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] phase
);

    import tick_sched_pkg::*;

    cfg_state_t       r_state;
    cfg_state_t       w_state_d;
    logic [2:0]       r_cfg_ch;
    logic [CNT_W-1:0] r_cfg_div;
    logic             r_cfg_en;
    logic             w_apply;
    logic             w_ch_valid;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        cfg_ready = 1'b0;
        w_apply   = 1'b0;
        case (r_state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_state_d = APPLY;
                end
            end
            APPLY: begin
                w_apply   = 1'b1;
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_cfg_ch  <= '0;
            r_cfg_div <= '0;
            r_cfg_en  <= 1'b0;
        end else if (cfg_valid && cfg_ready) begin
            r_cfg_ch  <= cfg_ch;
            r_cfg_div <= cfg_div;
            r_cfg_en  <= cfg_en;
        end
    end

    // Writes to channels that do not exist are dropped
    assign w_ch_valid = (32'(r_cfg_ch) < NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CNT_W-1:0] RstPeriod = (g == 0) ? CNT_W'(RST_DIV0) :
                                                 (g == 1) ? CNT_W'(RST_DIV1) : '0;

        logic [CNT_W-1:0] r_period;
        logic             r_en;
        logic             w_load;

        assign w_load = w_apply && w_ch_valid && (r_cfg_ch == 3'(g));

        always_ff @(posedge CLK) begin
            if (!RESET_N) begin
                r_period <= RstPeriod;
                r_en     <= RST_EN[g];
            end else if (w_load) begin
                r_period <= r_cfg_div;
                r_en     <= r_cfg_en;
            end
        end

        tick_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .i_clk   (CLK),
            .i_rst_n (RESET_N),
            .i_period(r_period),
            .i_en    (r_en),
            .i_load  (w_load),
            .i_pause (pause),
            .o_tick  (tick[g]),
            .o_phase (phase[g])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: cycle scoreboard from a countdown model plus directed checks.
// Phase expectations follow TICK_PHASE_OUT_EN.
module tb_tick_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 20;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic            pause = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [2:0]      cfg_ch = '0;
    logic [CW-1:0]   cfg_div = '0;
    logic            cfg_en = 1'b0;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  phase;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    tick_scheduler #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .RST_DIV0(5),
        .RST_DIV1(104166),
        .RST_EN  (8'h03)
    ) u_dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .pause    (pause),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_en   (cfg_en),
        .tick     (tick),
        .phase    (phase)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] phase;
        logic           ready;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: per-channel countdown of cycles remaining until the next tick
    int unsigned    m_per [NCH];
    int unsigned    m_rem [NCH];
    bit             m_en  [NCH];
    logic [NCH-1:0] m_tick  = '0;
    logic [NCH-1:0] m_phase = '0;
    bit             m_apply = 1'b0;
    logic [2:0]     m_ch;
    int unsigned    m_div;
    bit             m_en_new;

    always @(posedge CLK) begin
        exp_t e;
        if (!RESET_N) begin
            for (int c = 0; c < NCH; c++) begin
                m_per[c] = (c == 0) ? 5 : (c == 1) ? 104166 : 0;
                m_en[c]  = (c < 2);
                m_rem[c] = m_per[c];
            end
            m_tick  = '0;
            m_phase = '0;
            m_apply = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (m_apply && int'(m_ch) == c) begin
                    m_per[c]   = m_div;
                    m_en[c]    = m_en_new;
                    m_rem[c]   = m_div;
                    m_tick[c]  = 1'b0;
                    m_phase[c] = 1'b0;
                end else if (m_en[c] && m_per[c] != 0) begin
                    m_tick[c] = 1'b0;
                    if (!pause) begin
                        m_rem[c] = m_rem[c] - 1;
                        if (m_rem[c] == 0) begin
                            m_tick[c]  = 1'b1;
                            m_rem[c]   = m_per[c];
                            m_phase[c] = ~m_phase[c];
                        end
                    end
                end else begin
                    m_tick[c] = 1'b0;
                    m_rem[c]  = m_per[c];
                end
            end
            if (m_apply) begin
                m_apply = 1'b0;
            end else if (cfg_valid) begin
                m_apply  = 1'b1;
                m_ch     = cfg_ch;
                m_div    = int'(cfg_div);
                m_en_new = cfg_en;
            end
        end
        e.tick  = m_tick;
`ifdef TICK_PHASE_OUT_EN
        e.phase = m_phase;
`else
        e.phase = '0;
`endif
        e.ready = !m_apply;
        sb_q.push_back(e);
    end

    always @(negedge CLK) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_tick", 32'(tick), 32'(e.tick));
            check_eq("sb_phase", 32'(phase), 32'(e.phase));
            check_eq("sb_ready", 32'(cfg_ready), 32'(e.ready));
        end
    end

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Called at a negedge; returns at the negedge after the APPLY edge
    task automatic cfg_write(input logic [2:0] ch, input logic [CW-1:0] div, input logic en);
        int waited;
        waited    = 0;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        cfg_en    = en;
        while (!cfg_ready && waited < 8) begin
            @(negedge CLK);
            waited++;
        end
        check_eq("wr_ready_wait", 32'(waited < 8), 32'd1);
        @(negedge CLK);
        cfg_valid = 1'b0;
        check_eq("wr_busy", 32'(cfg_ready), 32'd0);
        @(negedge CLK);
        check_eq("wr_free", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        logic [4:0] rdy_seq;

        // Reset state
        wait_neg(3);
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("rst_phase", 32'(phase), 32'd0);
        check_eq("rst_ready", 32'(cfg_ready), 32'd1);
        RESET_N = 1'b1;

        // Period 5 after reset: ticks on cycles 5,10,15,20, ch2/3 silent
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            check_eq("t1_tick0", 32'(tick[0]), 32'((i % 5) == 0));
            check_eq("t1_tick23", 32'(tick[3:2]), 32'd0);
        end

        // Period 1 on ch2: tick every cycle
        cfg_write(3'd2, 20'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_eq("t2_tick2", 32'(tick[2]), 32'd1);
        end

        // Period 0 on ch0: silent
        cfg_write(3'd0, 20'd0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (tick[0]) cnt++;
        end
        check_eq("t3_tick0_cnt", 32'(cnt), 32'd0);

        // Period 4, pause for 7 cycles while cnt is 2
        cfg_write(3'd0, 20'd4, 1'b1);
        wait_neg(2);
        pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            check_eq("t4_pause_tick", 32'(tick), 32'd0);
        end
        pause = 1'b0;
        @(negedge CLK);
        check_eq("t4_resume1", 32'(tick[0]), 32'd0);
        @(negedge CLK);
        check_eq("t4_resume2", 32'(tick[0]), 32'd1);

        // APPLY lands on ch0 terminal count: suppressed, then period 3
        wait_neg(2);
        cfg_write(3'd0, 20'd3, 1'b1);
        check_eq("t5_suppressed", 32'(tick[0]), 32'd0);
        @(negedge CLK);
        check_eq("t5_gap1", 32'(tick[0]), 32'd0);
        @(negedge CLK);
        check_eq("t5_gap2", 32'(tick[0]), 32'd0);
        @(negedge CLK);
        check_eq("t5_next", 32'(tick[0]), 32'd1);

        // Reset during APPLY, then back-to-back writes to a missing channel
        @(negedge CLK);
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_div   = 20'd7;
        cfg_en    = 1'b1;
        @(negedge CLK);
        check_eq("t6_in_apply", 32'(cfg_ready), 32'd0);
        RESET_N   = 1'b0;
        cfg_valid = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        check_eq("t6_rst_tick", 32'(tick), 32'd0);
        cfg_valid  = 1'b1;
        cfg_ch     = 3'd7;
        cfg_div    = 20'd2;
        cfg_en     = 1'b1;
        rdy_seq[0] = cfg_ready;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            rdy_seq[k] = cfg_ready;
            check_eq("t6_tick0_early", 32'(tick[0]), 32'd0);
        end
        cfg_valid = 1'b0;
        check_eq("t6_ready_seq", 32'(rdy_seq), 32'b10101);
        @(negedge CLK);
        check_eq("t6_tick0_rst_div", 32'(tick[0]), 32'd1);
        check_eq("t6_tick23", 32'(tick[3:2]), 32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (tick[1]) cnt++;
        end
        check_eq("t6_ch1_lost_write", 32'(cnt), 32'd0);

        wait_neg(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
